aes_toplevel_ahb: RTL and testbench

AES_TOPLEVEL_AHB -- requirements
Module: aes_toplevel

---
 rtl/aes_toplevel_ahb.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_aes_toplevel_ahb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/aes_toplevel_ahb.sv
// AHB-Lite slave wrapping an iterative AES-128 core that runs 4 blocks.
// Ports: HCLK/HRESETn (active-high async), AHB-Lite slave bus, zero wait.
module aes_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         done
);
  typedef enum logic [1:0] {C_IDLE, C_KEXP, C_ENC, C_DEC} cst_t;
  cst_t         cst_q;
  logic [127:0] st_q, rk_q, nk, pk;
  logic [3:0]   rnd_q;
  logic         done_q;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    logic [7:0] y;
    y = a ^ 8'h63;
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < 10; j++)
      if (j < int'(n)) r = xt(r);
    return r;
  endfunction

  function automatic logic [31:0] kt(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ kt(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Walks the schedule backwards so decryption needs no stored round keys
  function automatic logic [127:0] kinv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    return {k[127:96] ^ kt(w3, rc), w1, w2, w3};
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s, input logic inv);
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] r;
    logic [127:0] o;
    m = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-8*(4*c+i) -: 8];
      for (int j = 0; j < 4; j++) begin
        r = '0;
        for (int i = 0; i < 4; i++) r = r ^ gmul(m[(i-j+4)%4], a[i]);
        o[127-8*(4*c+j) -: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd_fn(input logic [127:0] s, input logic [127:0] k,
                                          input logic last, input logic dec);
    logic [7:0]   a [16];
    logic [127:0] t;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = dec ? isbox(a[((c-r+4)%4)*4+r])
                                    : sbox(a[((c+r)%4)*4+r]);
    if (!dec && !last) t = mixc(t, 1'b0);
    t = t ^ k;
    if (dec && !last) t = mixc(t, 1'b1);
    return t;
  endfunction

  assign nk   = kexp(rk_q, rcon(rnd_q));
  assign pk   = kinv(rk_q, rcon(rnd_q));
  assign dout = st_q;
  assign done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cst_q  <= C_IDLE;
      st_q   <= '0;
      rk_q   <= '0;
      rnd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (cst_q)
        C_IDLE: if (start) begin
          rk_q  <= key;
          rnd_q <= 4'd1;
          st_q  <= decrypt ? din : din ^ key;
          cst_q <= decrypt ? C_KEXP : C_ENC;
        end
        C_KEXP: begin
          rk_q <= nk;
          if (rnd_q == 4'd10) begin
            st_q  <= st_q ^ nk;
            cst_q <= C_DEC;
          end else rnd_q <= rnd_q + 4'd1;
        end
        C_ENC: begin
          rk_q <= nk;
          st_q <= rnd_fn(st_q, nk, rnd_q == 4'd10, 1'b0);
          if (rnd_q == 4'd10) begin
            done_q <= 1'b1;
            cst_q  <= C_IDLE;
          end else rnd_q <= rnd_q + 4'd1;
        end
        C_DEC: begin
          rk_q <= pk;
          st_q <= rnd_fn(st_q, pk, rnd_q == 4'd1, 1'b1);
          if (rnd_q == 4'd1) begin
            done_q <= 1'b1;
            cst_q  <= C_IDLE;
          end else rnd_q <= rnd_q - 4'd1;
        end
      endcase
    end
  end
endmodule

module aes_toplevel_ahb (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELx,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_STORE} state_t;
  state_t       state_q;
  logic [1:0]   blk_q;
  logic         busy_q, done_q, start_q;
  logic         mode_q, mode_d;
  logic         dp_vld_q, dp_vld_d, dp_wr_q, dp_wr_d;
  logic [5:0]   dp_idx_q, dp_idx_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  in_q [16];
  logic [31:0]  in_d [16];
  logic [31:0]  out_q [16];
  logic         wr_en, go, core_done;
  logic [127:0] core_din, core_dout;
  logic         unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HSIZE, HTRANS[0], HADDR[31:8], HADDR[1:0]};
  assign HREADY = 1'b1;
  assign HRESP  = 2'b00;

  always_comb begin
    dp_vld_d = HSELx & HTRANS[1];
    dp_wr_d  = HWRITE;
    dp_idx_d = HADDR[7:2];
    wr_en    = dp_vld_q & dp_wr_q & ~busy_q;
    go       = wr_en & (dp_idx_q == 6'd31);
    mode_d   = mode_q;
    key_d    = key_q;
    in_d     = in_q;
    if (wr_en) begin
      unique case (1'b1)
        dp_idx_q == 6'd1:      mode_d = 1'b0;
        dp_idx_q == 6'd2:      mode_d = 1'b1;
        dp_idx_q[5:2] == 4'd1: key_d[{~dp_idx_q[1:0], 5'd0} +: 32] = HWDATA;
        dp_idx_q[5:4] == 2'd1: in_d[dp_idx_q[3:0]] = HWDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_vld_q && !dp_wr_q) begin
      unique case (1'b1)
        dp_idx_q == 6'd0:      HRDATA = {29'b0, mode_q, done_q, busy_q};
        dp_idx_q[5:4] == 2'd2: HRDATA = out_q[dp_idx_q[3:0]];
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_idx_q <= '0;
      mode_q   <= 1'b0;
      key_q    <= '0;
      for (int i = 0; i < 16; i++) in_q[i] <= '0;
    end else begin
      dp_vld_q <= dp_vld_d;
      dp_wr_q  <= dp_wr_d;
      dp_idx_q <= dp_idx_d;
      mode_q   <= mode_d;
      key_q    <= key_d;
      in_q     <= in_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      for (int i = 0; i < 16; i++) out_q[i] <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (go) begin
          state_q <= S_START;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          blk_q   <= '0;
          start_q <= 1'b1;
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: if (core_done) begin
          out_q[{blk_q, 2'd0}] <= core_dout[127:96];
          out_q[{blk_q, 2'd1}] <= core_dout[95:64];
          out_q[{blk_q, 2'd2}] <= core_dout[63:32];
          out_q[{blk_q, 2'd3}] <= core_dout[31:0];
          state_q <= S_STORE;
        end
        S_STORE: if (blk_q != 2'd3) begin
          blk_q   <= blk_q + 2'd1;
          state_q <= S_START;
          start_q <= 1'b1;
        end else begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign core_din = {in_q[{blk_q, 2'd0}], in_q[{blk_q, 2'd1}],
                     in_q[{blk_q, 2'd2}], in_q[{blk_q, 2'd3}]};

  aes_core u_core (
    .clk     (HCLK),
    .rst     (HRESETn),
    .start   (start_q),
    .decrypt (mode_q),
    .key     (key_q),
    .din     (core_din),
    .dout    (core_dout),
    .done    (core_done)
  );
endmodule

// File: tb/tb_aes_toplevel_ahb.sv
// Directed bench for aes_toplevel_ahb with a read-data scoreboard.
// Ports: drives all AHB inputs, checks HRDATA/HREADY/HRESP.
module tb_aes_toplevel_ahb;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        HSELx = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  aes_toplevel_ahb dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(HSELx), .HADDR(HADDR),
    .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  bit          pend_rd = 0;
  bit          pend_wr = 0;
  logic [31:0] pend_wd = '0;
  logic [31:0] last_rd = '0;

  logic [31:0] pt [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] ct [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
  logic [31:0] k1 [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  logic [31:0] k2 [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
  logic [31:0] p2 [4] = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
  logic [31:0] c2 [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};

  task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] ex);
    n_cmp++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tg, obs, ex);
    end
  endtask

  // One bus cycle: finish the previous data phase, then issue a new address phase
  task automatic step(input logic [1:0] tr, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] e, input string tg);
    logic [31:0] ex;
    string       t;
    HWDATA = pend_wr ? pend_wd : 32'h0;
    if (pend_rd) begin
      last_rd = HRDATA;
      ex = exp_q.pop_front();
      t  = tag_q.pop_front();
      if (t != "") check(t, HRDATA, ex);
    end
    HSELx  = (tr != 2'd0);
    HTRANS = tr;
    HADDR  = a;
    HWRITE = w;
    pend_rd = tr[1] && !w;
    pend_wr = tr[1] && w;
    pend_wd = d;
    if (pend_rd) begin
      exp_q.push_back(e);
      tag_q.push_back(tg);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(2'd2, 1'b1, a, d, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tg);
    step(2'd2, 1'b0, a, 32'h0, e, tg);
  endtask

  task automatic idle();
    step(2'd0, 1'b0, 32'h0, 32'h0, 32'h0, "");
  endtask

  task automatic wait_idle(input string tg);
    int n = 0;
    do begin
      rd(32'h0, 32'h0, "");
      idle();
      n++;
    end while (last_rd[0] && n < 400);
    check({tg, "_timeout"}, {31'b0, last_rd[0]}, 32'h0);
  endtask

  task automatic do_reset(input string tg);
    HSELx = 1'b0;
    HTRANS = 2'd0;
    HRESETn = 1'b1;
    #1;
    check({tg, "_hrdata"}, HRDATA, 32'h0);
    check({tg, "_hready"}, {31'b0, HREADY}, 32'h1);
    check({tg, "_hresp"}, {30'b0, HRESP}, 32'h0);
    pend_rd = 0;
    pend_wr = 0;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
  endtask

  initial begin
    @(posedge HCLK);
    #1;
    do_reset("rst0");

    rd(32'h00, 32'h0, "rst_status");
    rd(32'h80, 32'h0, "rst_out0");
    idle();

    // key burst, INCR
    HBURST = 3'b001;
    for (int i = 0; i < 4; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b1, 32'h10 + 4*i, k1[i], 32'h0, "");
    HBURST = 3'b000;
    rd(32'h10, 32'h0, "key_readback");
    rd(32'h00, 32'h0, "status_pre");
    idle();

    // encrypt run
    wr(32'h04, 32'h0);
    for (int i = 0; i < 16; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b1, 32'h40 + 4*i, pt[i%4], 32'h0, "");
    wait_idle("enc");
    rd(32'h00, 32'h2, "enc_status");
    for (int i = 0; i < 16; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b0, 32'h80 + 4*i, 32'h0, ct[i%4],
           $sformatf("enc_out%0d", i));
    rd(32'h40, 32'h0, "wo_input_read");
    rd(32'hFC, 32'h0, "unmapped_read");
    wr(32'h00, 32'hffffffff);
    rd(32'h00, 32'h2, "ro_status_write");
    idle();

    // decrypt run with reads and ignored writes while busy
    wr(32'h08, 32'h0);
    for (int i = 0; i < 16; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b1, 32'h40 + 4*i, ct[i%4], 32'h0, "");
    for (int i = 0; i < 16; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b0, 32'h80 + 4*i, 32'h0, ct[i%4],
           $sformatf("busy_old%0d", i));
    rd(32'h00, 32'h5, "busy_status");
    wr(32'h40, 32'hdeadbeef);
    wr(32'h50, 32'hdeadbeef);
    wr(32'h10, 32'hdeadbeef);
    wr(32'h04, 32'h0);
    idle();
    wait_idle("dec");
    rd(32'h00, 32'h6, "dec_status");
    for (int i = 0; i < 16; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b0, 32'h80 + 4*i, 32'h0, pt[i%4],
           $sformatf("dec_out%0d", i));
    idle();

    // reset in the middle of a run
    wr(32'h04, 32'h0);
    wr(32'h7C, 32'h0);
    rd(32'h00, 32'h1, "run_status");
    idle();
    idle();
    do_reset("rst1");
    rd(32'h00, 32'h0, "rst1_status");
    for (int i = 0; i < 16; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b0, 32'h80 + 4*i, 32'h0, 32'h0,
           $sformatf("rst1_out%0d", i));
    idle();

    // fresh run after reset, second known-answer vector
    for (int i = 0; i < 4; i++) wr(32'h10 + 4*i, k2[i]);
    for (int i = 0; i < 16; i++) wr(32'h40 + 4*i, p2[i%4]);
    wait_idle("enc2");
    rd(32'h00, 32'h2, "enc2_status");
    for (int i = 0; i < 16; i++)
      step(i == 0 ? 2'd2 : 2'd3, 1'b0, 32'h80 + 4*i, 32'h0, c2[i%4],
           $sformatf("enc2_out%0d", i));
    idle();
    check("end_hready", {31'b0, HREADY}, 32'h1);
    check("end_hresp", {30'b0, HRESP}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
